// File: rtl/irq_pkg.sv
// Shared types and defaults for the external interrupt source controller.
package irq_pkg;

    // Dispatch FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } irq_state_e;

    localparam int unsigned DEF_NUM_IRQ   = 4;
    localparam int unsigned DEF_PULSE_LEN = 1;
    localparam int unsigned DEF_MIN_GAP   = 2;

    // Wide enough for PULSE_LEN-1 (max 3) and MIN_GAP-1 (max 14)
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible request vector.
module irq_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_source_ctrl.sv
// External interrupt source: latches request edges, arbitrates by fixed
// priority, pulses the core's interrupt input and then holds off further
// dispatch until the core retires RTI and a refill gap has elapsed.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrating eligible pending lines every cycle
// PULSE   | interrupt held high, PULSE_LEN cycles via down-counter
// SERVICE | handler running, waiting for rti_done
// GAP     | MIN_GAP idle cycles before arbitration resumes
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = DEF_NUM_IRQ,
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
    parameter int unsigned MIN_GAP   = DEF_MIN_GAP,
    localparam int unsigned IDW      = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               rti_done,
    output logic               interrupt,
    output logic [IDW-1:0]     irq_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    irq_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_IRQ-1:0] prev_req_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [IDW-1:0]     irq_id_q;
    logic               interrupt_q;
    logic               in_service_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_valid;
    logic [IDW-1:0]     win_idx;

    assign eligible = pending_q & ~irq_mask;

    irq_prio_enc #(
        .N  (NUM_IRQ),
        .IW (IDW)
    ) u_prio (
        .eligible_i (eligible),
        .valid_o    (win_valid),
        .idx_o      (win_idx)
    );

    // Edge capture and pending update; a new edge beats a same-cycle clear
    always_comb begin
        rise = irq_req & ~prev_req_q;
        clr  = '0;
        if (state_q == ST_IDLE && win_valid) begin
            clr[win_idx] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    // Dispatch FSM with registered outputs and shared down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prev_req_q   <= '0;
            pending_q    <= '0;
            irq_id_q     <= '0;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            prev_req_q <= irq_req;
            pending_q  <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_q      <= ST_PULSE;
                        irq_id_q     <= win_idx;
                        interrupt_q  <= 1'b1;
                        in_service_q <= 1'b1;
                        cnt_q        <= CNT_W'(PULSE_LEN - 1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_SERVICE;
                        interrupt_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (rti_done) begin
                        if (MIN_GAP == 0) begin
                            state_q      <= ST_IDLE;
                            in_service_q <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                            cnt_q   <= CNT_W'(MIN_GAP - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    interrupt_q  <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt  = interrupt_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Bench for irq_source_ctrl: two instances (PULSE_LEN=1/MIN_GAP=2 and
// PULSE_LEN=3/MIN_GAP=0) share stimulus; a timestamp model checks both
// every cycle and directed literal checks pin the expected timeline.
module tb_irq_source_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] irq_req = '0;
    logic [3:0] irq_mask = '0;
    logic       rti_done = 1'b0;

    logic       int0, int1, svc0, svc1;
    logic [1:0] id0, id1;
    logic [3:0] pend0, pend1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    irq_source_ctrl #(.NUM_IRQ(4), .PULSE_LEN(1), .MIN_GAP(2)) u0 (
        .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
        .rti_done(rti_done), .interrupt(int0), .irq_id(id0),
        .in_service(svc0), .pending(pend0)
    );

    irq_source_ctrl #(.NUM_IRQ(4), .PULSE_LEN(3), .MIN_GAP(0)) u1 (
        .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
        .rti_done(rti_done), .interrupt(int1), .irq_id(id1),
        .in_service(svc1), .pending(pend1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model: dispatch/rti timestamps per instance ----------
    int         pl_m[2] = '{1, 3};
    int         mg_m[2] = '{2, 0};
    logic [3:0] m_pend[2];
    logic [3:0] m_prev[2];
    logic [1:0] m_id[2];
    bit         has_d[2];
    bit         has_r[2];
    int         d_e[2];
    int         r_e[2];
    int         n_e = 0;

    function automatic bit idle_at(input int i, input int k);
        return !has_d[i] || (has_r[i] && k >= r_e[i] + mg_m[i]);
    endfunction

    function automatic bit service_at(input int i, input int k);
        return has_d[i] && !has_r[i] && k >= d_e[i] + pl_m[i];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0; m_prev[i] = '0; m_id[i] = '0;
            has_d[i] = 1'b0; has_r[i] = 1'b0; d_e[i] = 0; r_e[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        logic [3:0] elig;
        logic [3:0] clr;
        int         w;
        int         pre;
        pre  = n_e - 1;
        elig = m_pend[i] & ~irq_mask;
        clr  = '0;
        if (service_at(i, pre) && rti_done) begin
            has_r[i] = 1'b1;
            r_e[i]   = n_e;
        end else if (idle_at(i, pre) && elig != 0) begin
            w = 0;
            for (int j = 3; j >= 0; j--) if (elig[j]) w = j;
            has_d[i] = 1'b1;
            has_r[i] = 1'b0;
            d_e[i]   = n_e;
            m_id[i]  = 2'(w);
            clr[w]   = 1'b1;
        end
        m_pend[i] = (m_pend[i] & ~clr) | (irq_req & ~m_prev[i]);
        m_prev[i] = irq_req;
    endtask

    always @(negedge reset) model_clear();

    always @(posedge clk) begin
        n_e++;
        if (!reset) model_clear();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_int0", {31'b0, int0}, 0);
            chk("rst_int1", {31'b0, int1}, 0);
            chk("rst_pend0", {28'b0, pend0}, 0);
            chk("rst_pend1", {28'b0, pend1}, 0);
        end else begin
            chk("m_int0", {31'b0, int0},
                {31'b0, has_d[0] && n_e >= d_e[0] && n_e <= d_e[0] + pl_m[0] - 1});
            chk("m_int1", {31'b0, int1},
                {31'b0, has_d[1] && n_e >= d_e[1] && n_e <= d_e[1] + pl_m[1] - 1});
            chk("m_svc0", {31'b0, svc0}, {31'b0, !idle_at(0, n_e)});
            chk("m_svc1", {31'b0, svc1}, {31'b0, !idle_at(1, n_e)});
            chk("m_id0", {30'b0, id0}, {30'b0, m_id[0]});
            chk("m_id1", {30'b0, id1}, {30'b0, m_id[1]});
            chk("m_pend0", {28'b0, pend0}, {28'b0, m_pend[0]});
            chk("m_pend1", {28'b0, pend1}, {28'b0, m_pend[1]});
        end
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic finish_service();
        rti_done = 1'b1; step(); rti_done = 1'b0;
        step(); step();
    endtask

    initial begin
        int pulses;
        int k;
        model_clear();
        repeat (3) step();
        chk("reset_int", {31'b0, int0}, 0);
        chk("reset_svc", {31'b0, svc0}, 0);
        chk("reset_pend", {28'b0, pend0}, 0);
        chk("reset_id", {30'b0, id0}, 0);
        reset = 1'b1;
        step();

        // single request on line 2
        irq_req = 4'b0100; step();
        chk("t1_pend_latched", {28'b0, pend0}, 4'b0100);
        chk("t1_no_int_yet", {31'b0, int0}, 0);
        step();
        chk("t1_int", {31'b0, int0}, 1);
        chk("t1_id", {30'b0, id0}, 2);
        chk("t1_svc", {31'b0, svc0}, 1);
        chk("t1_pend_clr", {28'b0, pend0}, 0);
        step();
        chk("t1_pulse_len", {31'b0, int0}, 0);
        chk("t1_svc_hold", {31'b0, svc0}, 1);
        rti_done = 1'b1; step(); rti_done = 1'b0;
        chk("t1_gap0", {31'b0, svc0}, 1);
        step();
        chk("t1_gap1", {31'b0, svc0}, 1);
        step();
        chk("t1_idle", {31'b0, svc0}, 0);

        // simultaneous lines 3 and 1
        irq_req = 4'b1010; step();
        chk("t2_pend", {28'b0, pend0}, 4'b1010);
        step();
        chk("t2_int", {31'b0, int0}, 1);
        chk("t2_id_first", {30'b0, id0}, 1);
        chk("t2_pend_left", {28'b0, pend0}, 4'b1000);
        step();
        rti_done = 1'b1; step(); rti_done = 1'b0;
        step(); step();
        chk("t2_gap_done", {31'b0, svc0}, 0);
        chk("t2_gap_no_int", {31'b0, int0}, 0);
        step();
        chk("t2_int_second", {31'b0, int0}, 1);
        chk("t2_id_second", {30'b0, id0}, 3);
        step();
        finish_service();

        // masked line still latches, dispatches once unmasked
        irq_req = 4'b0000; irq_mask = 4'b0001; step();
        irq_req = 4'b0001; step();
        chk("t3_pend_masked", {28'b0, pend0}, 4'b0001);
        step(); step();
        chk("t3_no_int", {31'b0, int0}, 0);
        chk("t3_idle", {31'b0, svc0}, 0);
        irq_mask = 4'b0000; step();
        chk("t3_int", {31'b0, int0}, 1);
        chk("t3_id", {30'b0, id0}, 0);
        step();

        // repeated edges during SERVICE collapse to one
        irq_req = 4'b0011; step();
        irq_req = 4'b0001; step();
        irq_req = 4'b0011; step();
        irq_req = 4'b0001; step();
        chk("t4_pend", {28'b0, pend0}, 4'b0010);
        chk("t4_no_int", {31'b0, int0}, 0);
        chk("t4_svc", {31'b0, svc0}, 1);
        finish_service();
        step();
        chk("t4_int", {31'b0, int0}, 1);
        chk("t4_id", {30'b0, id0}, 1);
        chk("t4_pend_clr", {28'b0, pend0}, 0);
        step();
        finish_service();
        pulses = 0;
        repeat (6) begin step(); if (int0) pulses++; end
        chk("t4_single_dispatch", pulses, 0);

        // rti_done ignored in IDLE and PULSE
        rti_done = 1'b1; step(); rti_done = 1'b0;
        chk("t5_idle_rti_svc", {31'b0, svc0}, 0);
        chk("t5_idle_rti_int", {31'b0, int0}, 0);
        irq_req = 4'b0101; step(); step();
        chk("t5_int", {31'b0, int0}, 1);
        rti_done = 1'b1; step(); rti_done = 1'b0;
        chk("t5_pulse_end", {31'b0, int0}, 0);
        chk("t5_still_svc", {31'b0, svc0}, 1);
        repeat (3) step();
        chk("t5_waits_rti", {31'b0, svc0}, 1);
        finish_service();
        chk("t5_released", {31'b0, svc0}, 0);

        // drain both instances
        irq_req = 4'b0000;
        k = 0;
        while (k < 40 && (svc0 || svc1 || pend0 != 0 || pend1 != 0)) begin
            rti_done = 1'b1; step(); rti_done = 1'b0; step();
            k++;
        end
        chk("t6_quiet_svc1", {31'b0, svc1}, 0);
        chk("t6_quiet_pend1", {28'b0, pend1}, 0);

        // reset mid-pulse on the PULSE_LEN=3 instance
        irq_req = 4'b1000; step(); step();
        chk("t6_int1", {31'b0, int1}, 1);
        irq_req = 4'b1100; step();
        chk("t6_int1_held", {31'b0, int1}, 1);
        chk("t6_pend1", {28'b0, pend1}, 4'b0100);
        #2 reset = 1'b0;
        #1;
        chk("t6_abort_int", {31'b0, int1}, 0);
        chk("t6_abort_pend", {28'b0, pend1}, 0);
        chk("t6_abort_svc", {31'b0, svc1}, 0);
        chk("t6_abort_svc0", {31'b0, svc0}, 0);
        irq_req = 4'b0000;
        step(); step();
        reset = 1'b1;
        pulses = 0;
        repeat (8) begin step(); if (int0 || int1) pulses++; end
        chk("t6_no_pulse_after", pulses, 0);
        chk("t6_pend_after", {28'b0, pend1}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
